// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial transmitter.
// Holds the FSM state type and the default parameter values used by
// p2s_if, p2s_shreg and p2s_tx.
package p2s_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned LEN_W_DEF = 4;
  localparam int unsigned GAP_DEF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } p2s_state_e;

endpackage

// File: rtl/p2s_if.sv
// Handshake and serial-output bundle of the transmitter.
//   data_in    : word to send, bits [len-1:0] go out MSB-first
//   len        : number of bits N in the frame
//   start      : frame request, honoured only while ready=1
//   ready      : transmitter idle, next start accepted
//   data_out   : serial data bit
//   enable_out : qualifies data_out, high for exactly N cycles
//   done       : one-cycle pulse after the last bit
//   bit_count  : bits already sent in the current frame
// master = requester side, slave = transmitter side.
interface p2s_if
  import p2s_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
);

  logic [WIDTH-1:0] data_in;
  logic [LEN_W-1:0] len;
  logic             start;
  logic             ready;
  logic             data_out;
  logic             enable_out;
  logic             done;
  logic [LEN_W-1:0] bit_count;

  modport master (
    output data_in, len, start,
    input  ready, data_out, enable_out, done, bit_count
  );

  modport slave (
    input  data_in, len, start,
    output ready, data_out, enable_out, done, bit_count
  );

endinterface

// File: rtl/p2s_shreg.sv
// Loadable left-shift register with MSB tap and bit counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : load data_i and clear the counter
//   data_i       : pre-aligned word (first bit at the MSB)
//   shift_i      : shift left by one and count one bit
//   clr_i        : clear the counter only
//   msb_o        : current MSB (bit on the line this cycle)
//   count_o      : bits shifted since the last load/clear
module p2s_shreg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  input  logic             clr_i,
  output logic             msb_o,
  output logic [LEN_W-1:0] count_o
);

  logic [WIDTH-1:0] sh_q;
  logic [LEN_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= data_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
      cnt_q <= cnt_q + LEN_W'(1);
    end else if (clr_i) begin
      cnt_q <= '0;
    end
  end

  assign msb_o   = sh_q[WIDTH-1];
  assign count_o = cnt_q;

endmodule

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter top: handshake FSM (IDLE/SHIFT/GAP)
// driving a p2s_shreg datapath.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset, aborts any frame
//   bus   : p2s_if slave side (data_in, len, start in;
//           ready, data_out, enable_out, done, bit_count out)
module p2s_tx
  import p2s_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned GAP   = GAP_DEF
) (
  input  logic    clk,
  input  logic    reset,
  p2s_if.slave    bus
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  p2s_state_e       state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             load, shift, clr;
  logic             msb;
  logic [LEN_W-1:0] cnt;
  logic [WIDTH-1:0] aligned;

  // Left-align so bit N-1 lands on the MSB; bits above N-1 fall off.
  // len=0 shifts by WIDTH and yields zero, which is harmless.
  assign aligned = bus.data_in << (WIDTH - bus.len);

  p2s_shreg #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_shreg (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (load),
    .data_i  (aligned),
    .shift_i (shift),
    .clr_i   (clr),
    .msb_o   (msb),
    .count_o (cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    len_d   = len_q;
    load    = 1'b0;
    shift   = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load  = 1'b1;
          len_d = bus.len;
          gap_d = '0;
          state_d = (bus.len == '0) ? ST_GAP : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        // cnt still shows bits sent before this one, so this is the last bit.
        if (cnt == len_q - LEN_W'(1)) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The first GAP cycle is the cycle right after the last bit (or right
  // after a len=0 acceptance), so done is decoded from it.
  assign bus.ready      = (state_q == ST_IDLE);
  assign bus.enable_out = (state_q == ST_SHIFT);
  assign bus.data_out   = (state_q == ST_SHIFT) & msb;
  assign bus.done       = (state_q == ST_GAP) && (gap_q == '0);
  assign bus.bit_count  = cnt;

endmodule

// File: tb/tb_p2s_tx.sv
// Directed bench for p2s_tx with a shift-in receiver model.
module tb_p2s_tx;
  import p2s_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  p2s_if #(.WIDTH(16), .LEN_W(4)) bus ();

  p2s_tx #(.WIDTH(16), .LEN_W(4), .GAP(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Results of the last send_frame call.
  logic [15:0] rx_word;
  int          en_n, done_n, done_idx, first_en, gap_n;
  logic [3:0]  bc_log [0:39];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(bus.ready), 1);
    chk({tag, "_en"},    32'(bus.enable_out), 0);
    chk({tag, "_dout"},  32'(bus.data_out), 0);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk({tag, "_bc"},    32'(bus.bit_count), 0);
  endtask

  // Issue one start, scramble the inputs after acceptance, then collect the
  // serial stream until ready returns (bounded at 40 cycles).
  task automatic send_frame(input logic [15:0] d, input logic [3:0] n);
    bus.data_in = d;
    bus.len     = n;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
    bus.data_in = ~d;
    bus.len     = ~n;
    rx_word = '0; en_n = 0; done_n = 0; done_idx = -1; first_en = -1; gap_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready) break;
      bc_log[i] = bus.bit_count;
      if (bus.enable_out) begin
        rx_word = {rx_word[14:0], bus.data_out};
        if (first_en < 0) first_en = i;
        en_n++;
      end else begin
        gap_n++;
      end
      if (bus.done) begin
        done_n++;
        done_idx = i;
      end
      step();
    end
    chk("ready_back", 32'(bus.ready), 1);
  endtask

  logic [19:0] en_log, d_log;
  int          hold_done;
  logic [15:0] rd;
  logic [3:0]  rn;

  initial begin
    bus.data_in = '0;
    bus.len     = '0;
    bus.start   = 1'b0;
    reset       = 1'b1;
    step();
    step();
    chk_idle("rst");
    reset = 1'b0;
    step();

    // 0x00A5, 8 bits: 1,0,1,0,0,1,0,1 starting the cycle after start.
    send_frame(16'h00A5, 4'd8);
    chk("a5_word",  32'(rx_word), 32'h00A5);
    chk("a5_en",    32'(en_n), 8);
    chk("a5_first", 32'(first_en), 0);
    chk("a5_done",  32'(done_n), 1);
    chk("a5_didx",  32'(done_idx), 8);
    chk("a5_gap",   32'(gap_n), 2);
    chk("a5_bc0",   32'(bus.bit_count), 0);

    // 0xFFFF, 3 bits: only bits [2:0] go out.
    send_frame(16'hFFFF, 4'd3);
    chk("ff_word", 32'(rx_word), 32'h7);
    chk("ff_en",   32'(en_n), 3);
    chk("ff_bc1",  32'(bc_log[1]), 1);
    chk("ff_bc2",  32'(bc_log[2]), 2);
    chk("ff_bc3",  32'(bc_log[3]), 3);
    chk("ff_didx", 32'(done_idx), 3);

    // len=0: no enable, done on the next cycle, GAP cycles not ready.
    send_frame(16'hBEEF, 4'd0);
    chk("z_en",   32'(en_n), 0);
    chk("z_done", 32'(done_n), 1);
    chk("z_didx", 32'(done_idx), 0);
    chk("z_gap",  32'(gap_n), 2);

    // start held high: frame 0x9/4 then 0x6/4. Expected per-cycle logs:
    // cycles 0-3 frame 1, 4-5 GAP, 6 IDLE (accepts), 7-10 frame 2.
    // start drops at cycle 8 and must not produce a third frame.
    bus.data_in = 16'h0009;
    bus.len     = 4'd4;
    bus.start   = 1'b1;
    step();
    bus.data_in = 16'h0006;
    en_log = '0; d_log = '0; hold_done = 0;
    for (int i = 0; i < 20; i++) begin
      en_log[i] = bus.enable_out;
      d_log[i]  = bus.data_out;
      if (bus.done) hold_done++;
      if (i == 8) bus.start = 1'b0;
      step();
    end
    chk("hold_en",   32'(en_log), 32'h0078F);
    chk("hold_data", 32'(d_log),  32'h00309);
    chk("hold_done", 32'(hold_done), 2);
    chk("hold_rdy",  32'(bus.ready), 1);

    // Reset on the 3rd bit of a 10-bit frame aborts it without done.
    bus.data_in = 16'h02B3;
    bus.len     = 4'd10;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("ab_en3", 32'(bus.enable_out), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("ab");
    step();
    chk("ab_done2", 32'(bus.done), 0);
    send_frame(16'h1234, 4'd12);
    chk("ab_word", 32'(rx_word), 32'h0234);
    chk("ab_en",   32'(en_n), 12);

    // Random loopback against the receiver model.
    for (int k = 0; k < 200; k++) begin
      rd = 16'($urandom);
      rn = 4'($urandom_range(15, 1));
      send_frame(rd, rn);
      chk("rnd_word", 32'(rx_word), 32'(rd & 16'((32'd1 << rn) - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
